hex_digits_scanner: RTL and testbench
=====================================

# hex_digits_scanner

Time-multiplexed 4-digit seven-segment driver for the hex-digit display path. It consumes the 16-bit value from the hex-digits PIO output port plus per-digit decimal points. It produces anode, segment and decimal-point drive for a common-anode, active-low display module. A per-frame snapshot register prevents tearing, a blanking interval between digit slots prevents ghosting, and leading-zero suppression is optional.

## Interface
Parameters:
- CLK_DIV, default 50000: clk cycles per digit slot (≥2).
- BLANK_CYCLES, default 500: all-anodes-off cycles at the start of each slot (0 ≤ BLANK_CYCLES < CLK_DIV).
- LZ_BLANK, default 1: 1 enables leading-zero suppression.

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- hex_value  in  16  value to display; nibble d drives digit d (digit 0 = [3:0], rightmost).
- dp_in  in  4  decimal point request per digit, 1 = lit.
- enable  in  1  1 = display driven, 0 = all outputs off.
- an_n  out  4  anode drive, active-low, at most one bit low.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Prescaler pre counts 0..CLK_DIV-1. Digit index dig (2 bits) increments when pre wraps, and 3 wraps to 0.
- Snapshot: snap_val/snap_dp load hex_value/dp_in in the cycle where (pre,dig) = (0,0). This includes the first cycle after reset release. frame_start is high in that same cycle.
- hex_value/dp_in changes at other times have no effect until the next frame_start.
- Slot output, computed from pre, dig and the snapshot:
  - pre < BLANK_CYCLES, a blanked digit, or enable=0: an_n=4'hF, seg_n=7'h7F, dp_n=1.
  - Otherwise: an_n has bit dig low. seg_n = decode(snap_val nibble dig). dp_n = ~snap_dp[dig].
- Decode (seg_n hex): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Leading-zero blank, LZ_BLANK=1 only: digit d ∈ {3,2,1} is blanked iff nibbles d..3 are all zero and dp bits d..3 are all zero. Digit 0 is never blanked.
- enable only gates outputs. Counters and snapshot keep running, so deassert/reassert does not shift the slot phase.

## Timing
- an_n, seg_n, dp_n and frame_start are registered. They reflect the (pre,dig) of the previous cycle, so there is a 1-cycle pipeline delay.
- Reset asserted (async): an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_start=0, pre=0, dig=0, snapshot=0, all immediately.
- Frame period is 4·CLK_DIV cycles.
- Worst-case latency from a hex_value change to visible digits is 4·CLK_DIV+1 cycles. Best case is 1 cycle: the change is present in the frame_start cycle.
- frame_start is visible at the output 1 cycle after the load cycle, aligned with the first blank cycle of digit 0.
- Each digit is lit for exactly CLK_DIV−BLANK_CYCLES consecutive cycles per frame. It is never lit when another anode is low.
- With BLANK_CYCLES=0, slots are back-to-back. The anode switches in the same edge as seg_n, with no overlap.
- Reset released mid-frame restarts at (0,0) with a fresh snapshot.
- enable falling takes effect on the next edge (outputs off). Rising resumes at the current slot position, which may be mid-slot.

## Test plan
Use CLK_DIV=8 and BLANK_CYCLES=2 unless stated.

- **Reset:** hold reset_n=0 with hex_value=16'hFFFF → an_n=F, seg_n=7F, dp_n=1. Release reset → frame_start pulses once, then every 32 cycles.
- **Basic scan (LZ_BLANK=0):** hex_value=16'h12AF, dp_in=4'b0100 → per slot 2 cycles all-off, then 6 cycles lit. The digit sequence is:
  - an_n=E, seg_n=0E.
  - an_n=D, seg_n=08.
  - an_n=B, seg_n=24, dp_n=0.
  - an_n=7, seg_n=79.
- **Leading zeros (LZ_BLANK=1):** hex_value=16'h0030, dp_in=0 → digits 3 and 2 keep an_n=F for their whole slot. Digit 1 shows seg_n=30 and digit 0 shows seg_n=40. Then set dp_in=4'b1000 → digit 3 shows seg_n=40, dp_n=0, and digit 2 also shows 40.
- **Anti-tear:** change hex_value from 16'h1111 to 16'h2222 during digit-1 slot → the remaining slots show 79. The first 24 appears only after the next frame_start.
- **Enable gating:** drop enable in mid digit-2 lit phase → next cycle all off. Raise enable 5 cycles later → the display resumes within digit 2 or digit 3 at the unchanged phase. The frame_start period stays 32.
- **Async reset mid-frame:** assert reset_n during a lit cycle → outputs go off without a clock edge. On release, the scan restarts at digit 0 with the new snapshot.

Source files
------------

// File: rtl/hex_digits_scanner.sv
// Time-multiplexed 4-digit seven-segment driver for a common-anode, active-low display.
// The value is snapshotted once per frame, and each digit slot opens with a blanking interval.
module hex_digits_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] hex_value,
  input  logic [3:0]  dp_in,
  input  logic        enable,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] pre;
  logic [1:0]    dig;
  logic [15:0]   snap_val;
  logic [3:0]    snap_dp;

  logic          load;
  logic          pre_wrap;
  logic [15:0]   cur_val;
  logic [3:0]    cur_dp;
  logic [3:0]    nib;
  logic          lz_hit;
  logic          off;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign load     = (pre == '0) && (dig == 2'd0);
  assign pre_wrap = (pre == PW'(CLK_DIV - 1));

  // In the load cycle the snapshot register is not yet updated, so bypass it;
  // this gives the 1-cycle best-case latency and correct output when BLANK_CYCLES=0.
  always_comb begin
    cur_val = load ? hex_value : snap_val;
    cur_dp  = load ? dp_in : snap_dp;
    nib     = cur_val[{dig, 2'b00} +: 4];
    lz_hit  = 1'b0;
    case (dig)
      2'd3: lz_hit = (cur_val[15:12] == 4'h0) && (cur_dp[3] == 1'b0);
      2'd2: lz_hit = (cur_val[15:8] == 8'h00) && (cur_dp[3:2] == 2'b00);
      2'd1: lz_hit = (cur_val[15:4] == 12'h000) && (cur_dp[3:1] == 3'b000);
      default: lz_hit = 1'b0;
    endcase
    off     = (int'(pre) < BLANK_CYCLES) || !enable || ((LZ_BLANK != 0) && lz_hit);
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (!off) begin
      an_nxt  = ~(4'b0001 << dig);
      seg_nxt = decode(nib);
      dp_nxt  = ~cur_dp[dig];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre         <= '0;
      dig         <= 2'd0;
      snap_val    <= 16'h0000;
      snap_dp     <= 4'h0;
      an_n        <= 4'hF;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) dig <= dig + 2'd1;
      if (load) begin
        snap_val <= hex_value;
        snap_dp  <= dp_in;
      end
      an_n        <= an_nxt;
      seg_n       <= seg_nxt;
      dp_n        <= dp_nxt;
      frame_start <= load;
    end
  end

endmodule

// File: tb/tb_hex_digits_scanner.sv
// Bench for hex_digits_scanner: two instances (leading-zero blanking off/on) share stimulus
// and are checked every cycle against a frame-position model of the display.
module tb_hex_digits_scanner;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] hex_value;
  logic [3:0]  dp_in;
  logic        enable;
  logic [3:0]  an_n  [2];
  logic [6:0]  seg_n [2];
  logic        dp_n  [2];
  logic        fs    [2];

  int total = 0;
  int bad   = 0;
  int c     = 0;
  logic [15:0] fv  = 16'h0;
  logic [3:0]  fdp = 4'h0;
  logic [3:0]  e_an  [2];
  logic [6:0]  e_seg [2];
  logic        e_dp  [2];
  logic        e_fs;

  always #5 clk = ~clk;

  hex_digits_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .hex_value(hex_value), .dp_in(dp_in), .enable(enable),
    .an_n(an_n[0]), .seg_n(seg_n[0]), .dp_n(dp_n[0]), .frame_start(fs[0]));

  hex_digits_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .hex_value(hex_value), .dp_in(dp_in), .enable(enable),
    .an_n(an_n[1]), .seg_n(seg_n[1]), .dp_n(dp_n[1]), .frame_start(fs[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at t=%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // What the display should show for frame position pos, given the frame's value.
  task automatic model(input int pos, input bit lz, input logic en,
                       output logic [3:0] an, output logic [6:0] seg, output logic dp);
    int d, p;
    bit blank;
    d = pos / CLK_DIV;
    p = pos % CLK_DIV;
    blank = (p < BLANK) || !en;
    if (lz && d > 0 && (fv >> (4 * d)) == 16'h0 && (fdp >> d) == 4'h0) blank = 1'b1;
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    if (!blank) begin
      an  = 4'hF & ~(4'b0001 << d);
      seg = SEG[(fv >> (4 * d)) & 16'hF];
      dp  = ~fdp[d];
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, k ? "/lz1/an" : "/lz0/an"}, 32'(an_n[k]), 32'(e_an[k]));
      chk({tag, k ? "/lz1/seg" : "/lz0/seg"}, 32'(seg_n[k]), 32'(e_seg[k]));
      chk({tag, k ? "/lz1/dp" : "/lz0/dp"}, 32'(dp_n[k]), 32'(e_dp[k]));
      chk({tag, k ? "/lz1/fs" : "/lz0/fs"}, 32'(fs[k]), 32'(e_fs));
    end
  endtask

  task automatic set_off();
    for (int k = 0; k < 2; k++) begin
      e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
    end
    e_fs = 1'b0;
  endtask

  task automatic step(input string tag);
    int pos;
    @(posedge clk);
    if (!reset_n) begin
      set_off();
      c = 0;
    end else begin
      pos = c % FRAME;
      if (pos == 0) begin
        fv  = hex_value;
        fdp = dp_in;
      end
      for (int k = 0; k < 2; k++) model(pos, k[0], enable, e_an[k], e_seg[k], e_dp[k]);
      e_fs = (pos == 0);
      c++;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    hex_value = 16'hFFFF;
    dp_in     = 4'hF;
    enable    = 1'b1;
    run("reset", 3);

    @(negedge clk);
    reset_n   = 1'b1;
    hex_value = 16'h12AF;
    dp_in     = 4'b0100;
    run("basic", 2 * FRAME + 3);

    hex_value = 16'h0030;
    dp_in     = 4'b0000;
    run("lz", 2 * FRAME);
    dp_in = 4'b1000;
    run("lz_dp", 2 * FRAME);

    hex_value = 16'h1111;
    dp_in     = 4'b0000;
    while ((c % FRAME) != 0) step("tear_sync");
    run("tear_a", CLK_DIV + 3);
    hex_value = 16'h2222;
    run("tear_b", 2 * FRAME);

    while ((c % FRAME) != 2 * CLK_DIV + 4) step("en_sync");
    enable = 1'b0;
    run("en_off", 5);
    enable = 1'b1;
    run("en_on", 2 * FRAME);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int n = 0; n < 4; n++)
          hex_value[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      step("rand");
    end
    enable = 1'b1;

    while ((c % FRAME) != CLK_DIV + 5) step("ar_sync");
    hex_value = 16'hBEEF;
    dp_in     = 4'b0001;
    #2 reset_n = 1'b0;
    #1 set_off();
    check_all("async_rst");
    run("in_rst", 2);
    @(negedge clk);
    reset_n = 1'b1;
    run("post_rst", FRAME + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
